audio_decoder: RTL and testbench

//  Serial-to-parallel receiver for the audio_data/audio_ws bit stream.

---
 rtl/audio_decoder_if.sv | 40 ++++
 rtl/audio_decoder.sv | 124 ++++++++++++
 tb/tb_audio_decoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_decoder_if.sv
// Audio receive link bundle: serial data/word-select in, recovered word out.
// Latency: n/a (wires only).
// Backpressure: none; the serial stream cannot be stalled.
interface audio_decoder_if #(
  parameter int WORD_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 6
);
  logic                    audio_data;
  logic                    audio_ws;
  logic [WORD_WIDTH-1:0]   word_out;
  logic [SAMPLE_WIDTH-1:0] sample_out;
  logic                    channel_out;
  logic                    sample_valid;
  logic                    framing_err;
  logic [7:0]              err_count;

  // Stream source / result consumer side.
  modport master (
    output audio_data,
    output audio_ws,
    input  word_out,
    input  sample_out,
    input  channel_out,
    input  sample_valid,
    input  framing_err,
    input  err_count
  );

  // Decoder side.
  modport slave (
    input  audio_data,
    input  audio_ws,
    output word_out,
    output sample_out,
    output channel_out,
    output sample_valid,
    output framing_err,
    output err_count
  );
endinterface

// File: rtl/audio_decoder.sv
// Serial-to-parallel audio receiver: MSB-first words, each ws edge starts a word.
// Latency: word, channel and sample_valid update on the edge capturing the last bit.
// Backpressure: none; words are overwritten by the next one. Optional
// framing error counter is built when AUDIO_DECODER_ERR_CNT_EN is defined.
module audio_decoder #(
  parameter int WORD_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 6
) (
  input  logic            clk_audio_bit,
  input  logic            reset_n,
  audio_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  state_t                  state;
  logic                    ws_prev;
  logic [WORD_WIDTH-1:0]   shift;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    word_ch;
  logic                    ovr_seen;

  logic                    ws_edge;
  logic                    last_bit;
  logic                    err_set;
  logic [WORD_WIDTH-1:0]   shift_next;

  // Edge detect, next shift value and framing error condition for this bit.
  always_comb begin
    ws_edge    = (bus.audio_ws != ws_prev);
    shift_next = (shift << 1) | WORD_WIDTH'(bus.audio_data);
    last_bit   = (bit_cnt == CNT_W'(WORD_WIDTH - 1));
    // A ws edge while still receiving means the previous word was short;
    // the first bit after a completed word means it was over-long.
    err_set    = ws_edge ? (state == RECEIVE)
                         : (state == OVERRUN && !ovr_seen);
  end

  // Word framing FSM with registered outputs.
  always_ff @(posedge clk_audio_bit or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      ws_prev          <= 1'b0;
      shift            <= '0;
      bit_cnt          <= '0;
      word_ch          <= 1'b0;
      ovr_seen         <= 1'b0;
      bus.word_out     <= '0;
      bus.channel_out  <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.framing_err  <= 1'b0;
    end else begin
      ws_prev          <= bus.audio_ws;
      sample_valid_clr: begin
        bus.sample_valid <= 1'b0;
      end
      bus.framing_err  <= err_set;
      if (ws_edge) begin
        // Every ws transition starts a fresh word, whatever state we are in.
        shift    <= WORD_WIDTH'(bus.audio_data);
        bit_cnt  <= CNT_W'(1);
        word_ch  <= bus.audio_ws;
        ovr_seen <= 1'b0;
        if (WORD_WIDTH == 1) begin
          bus.word_out     <= WORD_WIDTH'(bus.audio_data);
          bus.channel_out  <= bus.audio_ws;
          bus.sample_valid <= 1'b1;
          state            <= OVERRUN;
        end else begin
          state <= RECEIVE;
        end
      end else begin
        case (state)
          IDLE: begin
            // Bits before the first ws edge carry no framing; drop them.
          end
          RECEIVE: begin
            shift   <= shift_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
              bus.word_out     <= shift_next;
              bus.channel_out  <= word_ch;
              bus.sample_valid <= 1'b1;
              state            <= OVERRUN;
            end
          end
          OVERRUN: begin
            // Only the first surplus bit is reported.
            ovr_seen <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sample_out = bus.word_out[SAMPLE_WIDTH-1:0];

`ifdef AUDIO_DECODER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of framing errors, cleared only by reset.
  always_ff @(posedge clk_audio_bit or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 8'h00;
    end else if (err_set && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_audio_decoder.sv
// Directed bench for audio_decoder: framing, back-to-back words, errors, reset.
// Latency: outputs sampled 1 time unit after each rising bit-clock edge.
// Backpressure: none; the bench drives one bit per clock.
module tb_audio_decoder;

  logic clk;
  logic reset_n;
  int   asserts;
  int   failures;
  int   cyc;
  int   both_cnt;

  int         v_cyc[$];
  logic [7:0] v_word[$];
  logic [5:0] v_samp[$];
  logic       v_ch[$];
  int         e_cyc[$];

  audio_decoder_if #(.WORD_WIDTH(8), .SAMPLE_WIDTH(6)) bus ();

  audio_decoder #(.WORD_WIDTH(8), .SAMPLE_WIDTH(6)) dut (
    .clk_audio_bit (clk),
    .reset_n       (reset_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_log();
    v_cyc.delete();
    v_word.delete();
    v_samp.delete();
    v_ch.delete();
    e_cyc.delete();
  endtask

  // Drive one bit mid-cycle, then sample just after the rising edge.
  task automatic step(input logic ws, input logic d);
    @(negedge clk);
    bus.audio_ws   = ws;
    bus.audio_data = d;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.sample_valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_word.push_back(bus.word_out);
      v_samp.push_back(bus.sample_out);
      v_ch.push_back(bus.channel_out);
    end
    if (bus.framing_err === 1'b1) e_cyc.push_back(cyc);
    if (bus.sample_valid === 1'b1 && bus.framing_err === 1'b1) both_cnt++;
  endtask

  task automatic send_bits(input logic ws, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(ws, bits[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    bus.audio_ws   = 1'b0;
    bus.audio_data = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.audio_ws   = 1'b0;
    bus.audio_data = 1'b0;
    repeat (2) @(negedge clk);
    asserts++;
    if (bus.word_out !== 8'h00) begin failures++; $display("FAIL reset_word got %h want 00", bus.word_out); end
    asserts++;
    if (bus.sample_out !== 6'h00) begin failures++; $display("FAIL reset_sample got %h want 00", bus.sample_out); end
    asserts++;
    if (bus.channel_out !== 1'b0) begin failures++; $display("FAIL reset_channel got %b want 0", bus.channel_out); end
    asserts++;
    if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.sample_valid); end
    asserts++;
    if (bus.framing_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", bus.framing_err); end
    asserts++;
    if (bus.err_count !== 8'h00) begin failures++; $display("FAIL reset_errcnt got %h want 00", bus.err_count); end
    reset_n = 1'b1;
    clear_log();
  endtask

  task automatic test_single_word();
    do_reset();
    send_bits(1'b1, 16'h001F, 7);
    asserts++;
    if (v_cyc.size() != 0) begin failures++; $display("FAIL single_early_valid got %0d pulses want 0", v_cyc.size()); end
    step(1'b1, 1'b1);
    asserts++;
    if (bus.sample_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b want 1", bus.sample_valid); end
    asserts++;
    if (bus.sample_out !== 6'h3F) begin failures++; $display("FAIL single_sample got %h want 3f", bus.sample_out); end
    asserts++;
    if (bus.word_out !== 8'h3F) begin failures++; $display("FAIL single_word got %h want 3f", bus.word_out); end
    asserts++;
    if (bus.channel_out !== 1'b1) begin failures++; $display("FAIL single_channel got %b want 1", bus.channel_out); end
    asserts++;
    if (e_cyc.size() != 0) begin failures++; $display("FAIL single_err got %0d pulses want 0", e_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_s [3];
    logic       exp_c [3];
    exp_s[0] = 6'h3F; exp_s[1] = 6'h00; exp_s[2] = 6'h2A;
    exp_c[0] = 1'b1;  exp_c[1] = 1'b0;  exp_c[2] = 1'b1;
    do_reset();
    send_bits(1'b1, 16'h003F, 8);
    send_bits(1'b0, 16'h0000, 8);
    send_bits(1'b1, 16'h002A, 8);
    asserts++;
    if (v_cyc.size() != 3) begin failures++; $display("FAIL b2b_count got %0d pulses want 3", v_cyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        asserts++;
        if (v_samp[i] !== exp_s[i]) begin failures++; $display("FAIL b2b_sample%0d got %h want %h", i, v_samp[i], exp_s[i]); end
        asserts++;
        if (v_ch[i] !== exp_c[i]) begin failures++; $display("FAIL b2b_channel%0d got %b want %b", i, v_ch[i], exp_c[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        asserts++;
        if (v_cyc[i] - v_cyc[i-1] != 8) begin failures++; $display("FAIL b2b_spacing%0d got %0d want 8", i, v_cyc[i] - v_cyc[i-1]); end
      end
    end
    asserts++;
    if (e_cyc.size() != 0) begin failures++; $display("FAIL b2b_err got %0d pulses want 0", e_cyc.size()); end
  endtask

  task automatic test_pre_edge_bits();
    do_reset();
    send_bits(1'b0, 16'h0007, 3);
    send_bits(1'b1, 16'h00A5, 8);
    asserts++;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL preedge_count got %0d pulses want 1", v_cyc.size()); end
    else begin
      asserts++;
      if (v_word[0] !== 8'hA5) begin failures++; $display("FAIL preedge_word got %h want a5", v_word[0]); end
    end
    asserts++;
    if (e_cyc.size() != 0) begin failures++; $display("FAIL preedge_err got %0d pulses want 0", e_cyc.size()); end
  endtask

  task automatic test_short_word();
    int t_edge;
    do_reset();
    send_bits(1'b1, 16'h0016, 5);
    t_edge = cyc + 1;
    send_bits(1'b0, 16'h003C, 8);
    asserts++;
    if (e_cyc.size() != 1) begin failures++; $display("FAIL short_errcount got %0d pulses want 1", e_cyc.size()); end
    else begin
      asserts++;
      if (e_cyc[0] != t_edge) begin failures++; $display("FAIL short_errcycle got %0d want %0d", e_cyc[0], t_edge); end
    end
    asserts++;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL short_validcount got %0d pulses want 1", v_cyc.size()); end
    else begin
      asserts++;
      if (v_cyc[0] != t_edge + 7) begin failures++; $display("FAIL short_validcycle got %0d want %0d", v_cyc[0], t_edge + 7); end
      asserts++;
      if (v_word[0] !== 8'h3C) begin failures++; $display("FAIL short_word got %h want 3c", v_word[0]); end
      asserts++;
      if (v_ch[0] !== 1'b0) begin failures++; $display("FAIL short_channel got %b want 0", v_ch[0]); end
    end
  endtask

  task automatic test_overrun();
    int c0;
    do_reset();
    c0 = cyc;
    send_bits(1'b1, 16'h040F, 11);
    asserts++;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL ovr_validcount got %0d pulses want 1", v_cyc.size()); end
    else begin
      asserts++;
      if (v_cyc[0] != c0 + 8) begin failures++; $display("FAIL ovr_validcycle got %0d want %0d", v_cyc[0], c0 + 8); end
    end
    asserts++;
    if (e_cyc.size() != 1) begin failures++; $display("FAIL ovr_errcount got %0d pulses want 1", e_cyc.size()); end
    else begin
      asserts++;
      if (e_cyc[0] != c0 + 9) begin failures++; $display("FAIL ovr_errcycle got %0d want %0d", e_cyc[0], c0 + 9); end
    end
    asserts++;
    if (bus.word_out !== 8'h81) begin failures++; $display("FAIL ovr_word_hold got %h want 81", bus.word_out); end
    asserts++;
    if (bus.sample_out !== 6'h01) begin failures++; $display("FAIL ovr_sample_hold got %h want 01", bus.sample_out); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_bits(1'b1, 16'h003F, 8);
    send_bits(1'b0, 16'h0007, 3);
    @(negedge clk);
    bus.audio_ws   = 1'b0;
    bus.audio_data = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    asserts++;
    if (bus.word_out !== 8'h00) begin failures++; $display("FAIL midrst_word got %h want 00", bus.word_out); end
    asserts++;
    if (bus.sample_out !== 6'h00) begin failures++; $display("FAIL midrst_sample got %h want 00", bus.sample_out); end
    asserts++;
    if (bus.channel_out !== 1'b0) begin failures++; $display("FAIL midrst_channel got %b want 0", bus.channel_out); end
    asserts++;
    if (bus.sample_valid !== 1'b0 || bus.framing_err !== 1'b0) begin
      failures++; $display("FAIL midrst_pulses got valid=%b err=%b want 0/0", bus.sample_valid, bus.framing_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    send_bits(1'b1, 16'h005A, 8);
    asserts++;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL midrst_next_count got %0d pulses want 1", v_cyc.size()); end
    else begin
      asserts++;
      if (v_word[0] !== 8'h5A || v_ch[0] !== 1'b1) begin
        failures++; $display("FAIL midrst_next_word got %h/%b want 5a/1", v_word[0], v_ch[0]);
      end
    end
    asserts++;
    if (e_cyc.size() != 0) begin failures++; $display("FAIL midrst_next_err got %0d pulses want 0", e_cyc.size()); end
  endtask

  task automatic test_err_count();
    logic [7:0] exp_cnt;
`ifdef AUDIO_DECODER_ERR_CNT_EN
    exp_cnt = 8'hFF;
`else
    exp_cnt = 8'h00;
`endif
    do_reset();
    for (int i = 0; i <= 300; i++) begin
      step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    asserts++;
    if (e_cyc.size() != 300) begin failures++; $display("FAIL errcnt_pulses got %0d want 300", e_cyc.size()); end
    asserts++;
    if (v_cyc.size() != 0) begin failures++; $display("FAIL errcnt_valid got %0d pulses want 0", v_cyc.size()); end
    asserts++;
    if (bus.err_count !== exp_cnt) begin failures++; $display("FAIL errcnt_value got %h want %h", bus.err_count, exp_cnt); end
  endtask

  initial begin
    asserts        = 0;
    failures       = 0;
    cyc            = 0;
    both_cnt       = 0;
    reset_n        = 1'b0;
    bus.audio_ws   = 1'b0;
    bus.audio_data = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_pre_edge_bits();
    test_short_word();
    test_overrun();
    test_mid_reset();
    test_err_count();
    asserts++;
    if (both_cnt != 0) begin failures++; $display("FAIL valid_err_overlap got %0d cycles want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
